// File: rtl/game_sequencer_pkg.sv
// Shared definitions for the game sequencer, datapath and display logic:
// state encodings, keyboard scan codes and the round-length preset table.
package game_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_SELECT    = 2'd0,
    ST_COUNTDOWN = 2'd1,
    ST_INGAME    = 2'd2,
    ST_FINISH    = 2'd3
  } state_e;

  localparam logic [8:0] KEY_ENTER = 9'h05A;
  localparam logic [8:0] KEY_ESC   = 9'h076;
  localparam logic [8:0] KEY_TAB   = 9'h00D;
  localparam logic [8:0] KEY_1     = 9'h016;
  localparam logic [8:0] KEY_2     = 9'h01E;
  localparam logic [8:0] KEY_3     = 9'h026;

  // Round length for a mode/preset pair: seconds for timed rounds,
  // words for word-count rounds. Index 3 is unused and falls back to preset 0.
  function automatic logic [6:0] preset_value(input logic mode, input logic [1:0] idx);
    logic [6:0] v;
    case ({mode, idx})
      3'b0_00: v = 7'd15;
      3'b0_01: v = 7'd30;
      3'b0_10: v = 7'd60;
      3'b1_00: v = 7'd10;
      3'b1_01: v = 7'd25;
      3'b1_10: v = 7'd50;
      default: v = mode ? 7'd10 : 7'd15;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/game_sequencer_tick_gen.sv
// Game tick divider: a down-counter that pulses tick for one cycle every
// DIV cycles. While clear is high it is held at its reload value, so the
// first tick after clear drops arrives DIV cycles later.
module tick_gen #(
  parameter int DIV = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] RELOAD = W'(DIV - 1);

  logic [W-1:0] count_q, count_d;

  // Next count: reload on clear or terminal count, otherwise decrement.
  always_comb begin
    count_d = count_q - W'(1);
    if (clear || count_q == '0) count_d = RELOAD;
  end

  assign tick = (count_q == '0) && !clear;

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) count_q <= RELOAD;
    else     count_q <= count_d;
  end

endmodule

// File: rtl/game_sequencer.sv
// Game round sequencer: mode/preset selection, 3 s countdown, in-game and
// finish phases, driven by keyboard press events and the datapath finish flag.
//
// state        | meaning
// ST_SELECT    | choose mode (TAB) and preset ('1'..'3'); ENTER starts
// ST_COUNTDOWN | counting down CD_TICKS game ticks; ESC aborts
// ST_INGAME    | round running; finish ends it, ESC aborts (ESC wins)
// ST_FINISH    | round done; ENTER or ESC returns to selection
module game_sequencer
  import game_sequencer_pkg::*;
#(
  parameter int TICK_DIV = 1000000,
  parameter int CD_TICKS = 300
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key_down,
  input  logic [8:0]   last_change,
  input  logic         key_valid,
  input  logic         finish,
  output logic [1:0]   state,
  output logic         mode,
  output logic [6:0]   value,
  output logic [1:0]   cd_sec,
  output logic [7:0]   rounds
);

  localparam int CW = (CD_TICKS > 0) ? $clog2(CD_TICKS + 1) : 1;

  state_e         state_q, state_d;
  logic           mode_q, mode_d;
  logic [1:0]     idx_q, idx_d;
  logic [6:0]     value_q, value_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [1:0]     cd_sec_q, cd_sec_d;
  logic [7:0]     rounds_q, rounds_d;
  logic [127:0]   held_q, held_d;

  logic       tick, tick_clear;
  logic       code_ok, press, esc;
  logic [6:0] code;

  // The divider only runs while counting down, restarting on every entry.
  assign tick_clear = (state_q != ST_COUNTDOWN);

  tick_gen #(.DIV(TICK_DIV)) u_tick_gen (
    .clk   (clk),
    .rst   (rst),
    .clear (tick_clear),
    .tick  (tick)
  );

  // Press detection: a make event for a key not already held. Codes above
  // 127 have no key_down bit and never count as presses.
  always_comb begin
    code    = last_change[6:0];
    code_ok = (last_change[8:7] == 2'b00);
    press   = key_valid && code_ok && key_down[code] && !held_q[code];
    esc     = press && (last_change == KEY_ESC);
    held_d  = held_q;
    if (key_valid && code_ok) held_d[code] = key_down[code];
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    rounds_d = rounds_q;
    case (state_q)
      ST_SELECT: begin
        if (press) begin
          case (last_change)
            KEY_TAB: begin
              mode_d = !mode_q;
              idx_d  = 2'd0;
            end
            KEY_1: idx_d = 2'd0;
            KEY_2: idx_d = 2'd1;
            KEY_3: idx_d = 2'd2;
            KEY_ENTER: begin
              state_d = ST_COUNTDOWN;
              cnt_d   = CW'(CD_TICKS);
            end
            default: ;
          endcase
        end
      end
      ST_COUNTDOWN: begin
        if (esc) begin
          state_d = ST_SELECT;
        end else begin
          if (tick && cnt_q != '0) cnt_d = cnt_q - CW'(1);
          if (cnt_d == '0) state_d = ST_INGAME;
        end
      end
      ST_INGAME: begin
        if (esc) begin
          state_d = ST_SELECT;
        end else if (finish) begin
          state_d = ST_FINISH;
          if (rounds_q != 8'hFF) rounds_d = rounds_q + 8'd1;
        end
      end
      ST_FINISH: begin
        if (press && (last_change == KEY_ENTER || last_change == KEY_ESC))
          state_d = ST_SELECT;
      end
      default: state_d = ST_SELECT;
    endcase
    value_d  = preset_value(mode_d, idx_d);
    cd_sec_d = (state_d == ST_COUNTDOWN) ? 2'((32'(cnt_d) + 32'd99) / 32'd100) : 2'd0;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_SELECT;
      mode_q   <= 1'b0;
      idx_q    <= 2'd0;
      value_q  <= 7'd15;
      cnt_q    <= '0;
      cd_sec_q <= 2'd0;
      rounds_q <= 8'd0;
      held_q   <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      idx_q    <= idx_d;
      value_q  <= value_d;
      cnt_q    <= cnt_d;
      cd_sec_q <= cd_sec_d;
      rounds_q <= rounds_d;
      held_q   <= held_d;
    end
  end

  assign state  = state_q;
  assign mode   = mode_q;
  assign value  = value_q;
  assign cd_sec = cd_sec_q;
  assign rounds = rounds_q;

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; ports are named clk and rst.
REQ-002 Parameter TICK_DIV, default 1000000, SHALL be the clk cycles per 10 ms game tick (100 MHz to 100 Hz).
REQ-003 Parameter CD_TICKS, default 300, SHALL be the countdown length in ticks (3 s).
REQ-004 clk  in  1  system clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 key_down  in  128  keyboard held-key vector from the keyboard decoder.
REQ-007 last_change  in  9  scan code of the most recent make/break event.
REQ-008 key_valid  in  1  one-cycle strobe qualifying last_change.
REQ-009 finish  in  1  round-complete flag from the game datapath.
REQ-010 state  out  2  0=SELECT, 1=COUNTDOWN, 2=INGAME, 3=FINISH.
REQ-011 mode  out  1  0=timed round, 1=word-count round.
REQ-012 value  out  7  round length: seconds (mode 0) or words (mode 1).
REQ-013 cd_sec  out  2  countdown seconds remaining (3,2,1), else 0.
REQ-014 rounds  out  8  completed-round count.

Function
REQ-015 A press SHALL be key_valid=1 with key_down[last_change]=1 and that code not already held on the previous press; repeats of a held key are ignored until its break.
REQ-016 Key codes: ENTER 9'h05A, ESC 9'h076, TAB 9'h00D, '1' 9'h016, '2' 9'h01E, '3' 9'h026.
REQ-017 In SELECT, TAB SHALL toggle mode and reset the preset index to 0.
REQ-018 In SELECT, '1'/'2'/'3' SHALL set the preset index to 0/1/2.
REQ-019 value SHALL be registered from a preset table: mode 0 gives 15/30/60; mode 1 gives 10/25/50.
REQ-020 value SHALL update on the cycle after the selecting press.
REQ-021 SELECT + ENTER SHALL go to COUNTDOWN and load the countdown counter with CD_TICKS.
REQ-022 The tick divider SHALL restart on entry to COUNTDOWN, so the first tick comes TICK_DIV cycles later.
REQ-023 In COUNTDOWN the counter SHALL decrement once per tick.
REQ-024 When the counter reaches 0, the next cycle SHALL be INGAME.
REQ-025 cd_sec SHALL equal ceil(counter/100) while in COUNTDOWN, and 0 in all other states.
REQ-026 COUNTDOWN + ESC SHALL return to SELECT; all other keys are ignored.
REQ-027 INGAME + finish=1 SHALL go to FINISH and increment rounds, saturating at 255.
REQ-028 INGAME + ESC SHALL go to SELECT; ESC has priority over finish in the same cycle, and rounds is not incremented.
REQ-029 FINISH + ENTER or ESC SHALL go to SELECT.
REQ-030 mode and value SHALL be held constant outside SELECT.
REQ-031 Presses in any state other than those listed SHALL have no effect.
REQ-032 All outputs SHALL be registered; a state change is visible one cycle after the causing press or tick.

Reset
REQ-033 On rst, the block SHALL set state=SELECT, mode=0, preset index 0 (value=15), cd_sec=0 and rounds=0, and clear the held-key tracking and the tick divider.
REQ-034 rst asserted in any state, including mid-countdown, SHALL take effect on the next clk edge with no pending transition.

Structure
REQ-035 The state encodings, the key-code constants and the preset table SHALL reside in a shared package used also by the game datapath and display logic.
REQ-036 The tick divider SHALL be a sub-module tick_gen with inputs clk, rst and clear, and a one-cycle output tick.

Verification
REQ-037 Reset, then press '3' -> value=60, mode=0; press TAB -> mode=1, value=10.
REQ-038 With TICK_DIV=4 and CD_TICKS=300, press ENTER -> state=1 and cd_sec=3; after 1200 cycles, state=2 and cd_sec=0.
REQ-039 In INGAME, drive finish=1 -> state=3 and rounds=1; then ENTER -> state=0.
REQ-040 In INGAME, press ESC in the same cycle as finish=1 -> state=0 and rounds=0.
REQ-041 Hold '2' and emit three make events without a break -> only one press registered; pressing '1' in COUNTDOWN leaves value unchanged.
REQ-042 Assert rst mid-countdown -> next cycle state=0, value=15, cd_sec=0.
